// File: rtl/six_bit_div_ctrl.sv
// Six-bit sequential restoring divider: one trial subtraction per cycle through a single sixbitsub.
// Define SIX_BIT_DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned values.

module sixbitsub (
    input  logic [5:0] a_i,
    input  logic [5:0] b_i,
    output logic [5:0] diff_o,
    output logic       borrow_o
);
    logic [6:0] full;

    assign full     = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o   = full[5:0];
    assign borrow_o = full[6];
endmodule

module six_bit_div_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] dividend,
    input  logic [5:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [5:0] quotient,
    output logic [5:0] remainder,
    output logic       divzero,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    state_t     state_q;
    logic [5:0] dvdRaw_q;
    logic [5:0] dvdMag_q;
    logic [5:0] dvsMag_q;
    logic       dvdNeg_q;
    logic       dvsNeg_q;
    logic [5:0] partRem_q;
    logic [5:0] quoShift_q;
    logic [2:0] count_q;
    logic [5:0] resQuo_q;
    logic [5:0] resRem_q;
    logic       resDz_q;
    logic       resOv_q;
    logic       busy_q;
    logic       done_q;
    logic [5:0] quotient_q;
    logic [5:0] remainder_q;
    logic       divzero_q;
    logic       overflow_q;

    logic [5:0] opDvdMag_d;
    logic [5:0] opDvsMag_d;
    logic       opDvdNeg_d;
    logic       opDvsNeg_d;
    logic       ovf_d;
    logic [6:0] shifted_d;
    logic [5:0] subDiff;
    logic       subBorrow;
    logic       geq_d;
    logic [5:0] newRem_d;
    logic [5:0] magQuo_d;
    logic       quoNeg_d;

`ifdef SIX_BIT_DIV_SIGNED_EN
    assign opDvdNeg_d = dividend[5];
    assign opDvsNeg_d = divisor[5];
    assign opDvdMag_d = dividend[5] ? 6'(-dividend) : dividend;
    assign opDvsMag_d = divisor[5]  ? 6'(-divisor)  : divisor;
    // Only -32 / -1 yields a positive quotient of 32, which does not fit.
    assign ovf_d      = dvdNeg_q && dvsNeg_q && (dvdMag_q == 6'd32) && (dvsMag_q == 6'd1);
`else
    assign opDvdNeg_d = 1'b0;
    assign opDvsNeg_d = 1'b0;
    assign opDvdMag_d = dividend;
    assign opDvsMag_d = divisor;
    assign ovf_d      = 1'b0;
`endif

    // The stored remainder is always below the divisor, so six bits suffice; the shifted value needs seven.
    assign shifted_d = {partRem_q, dvdMag_q[count_q]};

    sixbitsub u_sub (
        .a_i      (shifted_d[5:0]),
        .b_i      (dvsMag_q),
        .diff_o   (subDiff),
        .borrow_o (subBorrow)
    );

    assign geq_d    = shifted_d[6] | ~subBorrow;
    assign newRem_d = geq_d ? subDiff : shifted_d[5:0];
    assign magQuo_d = {quoShift_q[4:0], geq_d};
    assign quoNeg_d = dvdNeg_q ^ dvsNeg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvdRaw_q    <= '0;
            dvdMag_q    <= '0;
            dvsMag_q    <= '0;
            dvdNeg_q    <= 1'b0;
            dvsNeg_q    <= 1'b0;
            partRem_q   <= '0;
            quoShift_q  <= '0;
            count_q     <= '0;
            resQuo_q    <= '0;
            resRem_q    <= '0;
            resDz_q     <= 1'b0;
            resOv_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divzero_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvdRaw_q <= dividend;
                        dvdMag_q <= opDvdMag_d;
                        dvsMag_q <= opDvsMag_d;
                        dvdNeg_q <= opDvdNeg_d;
                        dvsNeg_q <= opDvsNeg_d;
                        busy_q   <= 1'b1;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    if (dvsMag_q == 6'd0) begin
                        resQuo_q <= 6'h3F;
                        resRem_q <= dvdRaw_q;
                        resDz_q  <= 1'b1;
                        resOv_q  <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        partRem_q  <= '0;
                        quoShift_q <= '0;
                        count_q    <= 3'd5;
                        resDz_q    <= 1'b0;
                        state_q    <= ITER;
                    end
                end
                ITER: begin
                    partRem_q  <= newRem_d;
                    quoShift_q <= magQuo_d;
                    count_q    <= count_q - 3'd1;
                    // Sign fix-up happens on the final step so DONE only has to publish.
                    if (count_q == 3'd0) begin
                        resQuo_q <= quoNeg_d ? 6'(-magQuo_d) : magQuo_d;
                        resRem_q <= dvdNeg_q ? 6'(-newRem_d) : newRem_d;
                        resOv_q  <= ovf_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    quotient_q  <= resQuo_q;
                    remainder_q <= resRem_q;
                    divzero_q   <= resDz_q;
                    overflow_q  <= resOv_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign divzero   = divzero_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_six_bit_div_ctrl.sv
// Self-checking bench for six_bit_div_ctrl: vector table, hand sequences and randomized divisions
// checked against an arithmetic reference model (honours SIX_BIT_DIV_SIGNED_EN).

module tb_six_bit_div_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       divzero;
    logic       overflow;

    always #5 clk = ~clk;

    six_bit_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divzero   (divzero),
        .overflow  (overflow)
    );

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] q;
        logic [5:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference: plain integer division; SV int division truncates toward zero like the spec.
    function automatic void model(input logic [5:0] a, input logic [5:0] b,
                                  output logic [5:0] q, output logic [5:0] r,
                                  output logic dz, output logic ov);
        int sa;
        int sb;
`ifdef SIX_BIT_DIV_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 6'h3F;
            r  = a;
            dz = 1'b1;
        end else if (sa == -32 && sb == -1) begin
            q  = 6'h20;
            r  = 6'h00;
            ov = 1'b1;
        end else begin
            q = 6'(sa / sb);
            r = 6'(sa % sb);
        end
    endfunction

    // Launch one division; returns the negedge index (after the accepting edge) where done was seen.
    task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input bit immediate,
                                 output int doneAt, output int busyCycles);
        if (!immediate) @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 6'($urandom);
        divisor  = 6'($urandom);
        doneAt     = 0;
        busyCycles = 0;
        for (int n = 1; n <= 20 && doneAt == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (busy) busyCycles++;
            if (done) doneAt = n;
        end
    endtask

    task automatic checkDivision(input string name, input logic [5:0] a, input logic [5:0] b,
                                 input logic [5:0] q, input logic [5:0] r, input logic dz,
                                 input logic ov, input bit immediate);
        int doneAt;
        int busyCycles;
        applyStimulus(a, b, immediate, doneAt, busyCycles);
        checkOutput($sformatf("%s latency", name), doneAt, dz ? 3 : 9);
        checkOutput($sformatf("%s busy cycles", name), busyCycles, dz ? 2 : 8);
        checkOutput($sformatf("%s quotient", name), int'(quotient), int'(q));
        checkOutput($sformatf("%s remainder", name), int'(remainder), int'(r));
        checkOutput($sformatf("%s divzero", name), int'(divzero), int'(dz));
        checkOutput($sformatf("%s overflow", name), int'(overflow), int'(ov));
    endtask

    initial begin
        logic [5:0] mq;
        logic [5:0] mr;
        logic       mdz;
        logic       mov;
        int         doneCount;
        int         doneAt;
        int         busySeen;

`ifdef SIX_BIT_DIV_SIGNED_EN
        vecs.push_back('{6'h2C, 6'd3,  6'h3A, 6'h3E, 1'b0, 1'b0});
        vecs.push_back('{6'h20, 6'h3F, 6'h20, 6'h00, 1'b0, 1'b1});
        vecs.push_back('{6'h3F, 6'd0,  6'h3F, 6'h3F, 1'b1, 1'b0});
        vecs.push_back('{6'd7,  6'h3E, 6'h3D, 6'd1,  1'b0, 1'b0});
        vecs.push_back('{6'h39, 6'd2,  6'h3D, 6'h3F, 1'b0, 1'b0});
        vecs.push_back('{6'd20, 6'd3,  6'd6,  6'd2,  1'b0, 1'b0});
        vecs.push_back('{6'h20, 6'd1,  6'h20, 6'd0,  1'b0, 1'b0});
        vecs.push_back('{6'h20, 6'h20, 6'd1,  6'd0,  1'b0, 1'b0});
`else
        vecs.push_back('{6'd45, 6'd7,  6'd6,  6'd3,  1'b0, 1'b0});
        vecs.push_back('{6'd63, 6'd0,  6'h3F, 6'd63, 1'b1, 1'b0});
        vecs.push_back('{6'd5,  6'd9,  6'd0,  6'd5,  1'b0, 1'b0});
        vecs.push_back('{6'd63, 6'd1,  6'd63, 6'd0,  1'b0, 1'b0});
        vecs.push_back('{6'd0,  6'd5,  6'd0,  6'd0,  1'b0, 1'b0});
        vecs.push_back('{6'd63, 6'd63, 6'd1,  6'd0,  1'b0, 1'b0});
        vecs.push_back('{6'd62, 6'd31, 6'd2,  6'd0,  1'b0, 1'b0});
        vecs.push_back('{6'd1,  6'd63, 6'd0,  6'd1,  1'b0, 1'b0});
        vecs.push_back('{6'd32, 6'd3,  6'd10, 6'd2,  1'b0, 1'b0});
`endif

        // Reset must win even with start asserted.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 6'd7;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset quotient", int'(quotient), 0);
        checkOutput("reset remainder", int'(remainder), 0);
        checkOutput("reset divzero", int'(divzero), 0);
        checkOutput("reset overflow", int'(overflow), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset busy", int'(busy), 0);

        // Table entries after the first are launched in the done cycle: no dead cycle allowed.
        foreach (vecs[i]) begin
            checkDivision($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                          vecs[i].dz, vecs[i].ov, i > 0);
        end

        // Start held high with operands churning while busy: one done, original operands used.
        model(6'd45, 6'd7, mq, mr, mdz, mov);
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 6'd7;
        doneCount = 0;
        doneAt    = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                if (doneAt == 0) doneAt = n;
            end
            if (n == 9) begin
                checkOutput("held quotient", int'(quotient), int'(mq));
                checkOutput("held remainder", int'(remainder), int'(mr));
            end
            if (n < 8) begin
                dividend = 6'($urandom);
                divisor  = 6'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("held done count", doneCount, 1);
        checkOutput("held done latency", doneAt, 9);
        checkOutput("hold quotient", int'(quotient), int'(mq));
        checkOutput("hold remainder", int'(remainder), int'(mr));

        // Reset at E+4 aborts the division and clears every output.
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 6'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", int'(busy), 0);
        doneCount = 0;
        busySeen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCount++;
            if (busy) busySeen++;
        end
        checkOutput("abort done count", doneCount, 0);
        checkOutput("abort busy seen", busySeen, 0);
        checkOutput("abort quotient", int'(quotient), 0);
        checkOutput("abort remainder", int'(remainder), 0);
        checkOutput("abort divzero", int'(divzero), 0);
        checkOutput("abort overflow", int'(overflow), 0);
        checkDivision("post-abort", 6'd45, 6'd7, mq, mr, mdz, mov, 1'b0);

        // Randomized divisions against the model, some back to back, some with zero divisor.
        for (int i = 0; i < 40; i++) begin
            logic [5:0] ra;
            logic [5:0] rb;
            ra = 6'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            if (i % 13 == 0) begin
                ra = 6'h20;
                rb = 6'h3F;
            end
            model(ra, rb, mq, mr, mdz, mov);
            checkDivision($sformatf("rand%0d %0d/%0d", i, ra, rb), ra, rb, mq, mr, mdz, mov,
                          $urandom_range(0, 1) == 1);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
